bus_arb2: RTL and testbench

Two-master round-robin arbiter that merges two req/ack/resp masters (e.g. CPU data port and debug/DMA loader) onto one slave port of the dual-port RAM wrapper. It forwards requests unchanged and tracks in-flight reads in a small ID FIFO so each read response returns to the master that issued it. It tolerates slave back-pressure (ack withheld during fractional write-back) and pipelined reads.

---
 rtl/bus_arb2_pkg.sv | 15 +
 rtl/bus_arb2_id_fifo.sv | 58 +++++
 rtl/bus_arb2.sv | 148 ++++++++++++++
 tb/tb_bus_arb2.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb2_pkg.sv
// Shared constants and types for the two-master bus arbiter family.
package bus_arb2_pkg;

    // Width of a master identifier carried through the response ID FIFO.
    localparam int MID_W = 1;

    typedef logic [MID_W-1:0] mid_t;

    localparam mid_t MID_M0 = 1'b0;
    localparam mid_t MID_M1 = 1'b1;

    // last_r resets to master 1 so that master 0 wins the first tie.
    localparam mid_t LAST_RST = MID_M1;

endpackage

// File: rtl/bus_arb2_id_fifo.sv
// Small ID FIFO tracking which master owns each outstanding read.
// Push is ignored when full, pop is ignored when empty.
module bus_arb2_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == '0);
    assign head      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage, pointers and occupancy count; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter onto one slave port. Requests are passed
// through combinationally; read ownership is tracked in an ID FIFO so each
// response is routed back to the master that issued the read.
module bus_arb2
    import bus_arb2_pkg::*;
#(
    parameter int RESP_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic        m0_resp_o,
    output logic        m1_resp_o,
    output logic [31:0] m0_rdata_bo,
    output logic [31:0] m1_rdata_bo,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_bo,
    output logic [3:0]  bus_be_bo,
    output logic [31:0] bus_wdata_bo,
    input  logic        bus_ack_i,
    input  logic        bus_resp_i,
    input  logic [31:0] bus_rdata_bi,
    output logic        resp_err_o
);

    mid_t grant_s;
    logic gvalid_s;
    logic sel_req_s;
    logic ack_s;
    logic push_s;
    logic fifo_full_s;
    logic fifo_empty_s;
    mid_t head_s;

    mid_t grant_r;
    logic lock_r;
    mid_t last_r;
    logic resp_err_r;

    // Grant selection: hold a locked grant, otherwise round-robin on ties.
    always_comb begin
        grant_s  = MID_M0;
        gvalid_s = 1'b0;
        if (lock_r) begin
            grant_s  = grant_r;
            gvalid_s = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            grant_s  = (last_r == MID_M0) ? MID_M1 : MID_M0;
            gvalid_s = 1'b1;
        end else if (m0_req_i) begin
            grant_s  = MID_M0;
            gvalid_s = 1'b1;
        end else if (m1_req_i) begin
            grant_s  = MID_M1;
            gvalid_s = 1'b1;
        end else begin
            grant_s  = MID_M0;
            gvalid_s = 1'b0;
        end
    end

    // Slave request mux; idle cycles present master 0 fields with req low.
    always_comb begin
        sel_req_s    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_bo  = 32'h0000_0000;
        bus_be_bo    = 4'h0;
        bus_wdata_bo = 32'h0000_0000;
        if (grant_s == MID_M1) begin
            sel_req_s    = m1_req_i;
            bus_we_o     = m1_we_i;
            bus_addr_bo  = m1_addr_bi;
            bus_be_bo    = m1_be_bi;
            bus_wdata_bo = m1_wdata_bi;
        end else begin
            sel_req_s    = m0_req_i;
            bus_we_o     = m0_we_i;
            bus_addr_bo  = m0_addr_bi;
            bus_be_bo    = m0_be_bi;
            bus_wdata_bo = m0_wdata_bi;
        end
        bus_req_o = gvalid_s && sel_req_s && !fifo_full_s;
    end

    assign ack_s    = bus_ack_i && bus_req_o;
    assign m0_ack_o = ack_s && (grant_s == MID_M0);
    assign m1_ack_o = ack_s && (grant_s == MID_M1);
    assign push_s   = ack_s && !bus_we_o;

    // Responses go to the master at the FIFO head; none when nothing is owed.
    assign m0_resp_o   = bus_resp_i && !fifo_empty_s && (head_s == MID_M0);
    assign m1_resp_o   = bus_resp_i && !fifo_empty_s && (head_s == MID_M1);
    assign m0_rdata_bo = bus_rdata_bi;
    assign m1_rdata_bo = bus_rdata_bi;
    assign resp_err_o  = resp_err_r;

    // Arbitration state: grant lock across back-pressure, round-robin history, error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_r    <= MID_M0;
            lock_r     <= 1'b0;
            last_r     <= LAST_RST;
            resp_err_r <= 1'b0;
        end else begin
            if (bus_req_o) begin
                grant_r <= grant_s;
            end
            if (bus_req_o && !bus_ack_i) begin
                lock_r <= 1'b1;
            end else if (ack_s) begin
                lock_r <= 1'b0;
            end
            if (ack_s) begin
                last_r <= grant_s;
            end
            if (bus_resp_i && fifo_empty_s) begin
                resp_err_r <= 1'b1;
            end
        end
    end

    bus_arb2_id_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (MID_W)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_s),
        .din   (grant_s),
        .pop   (bus_resp_i),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

endmodule

// File: tb/tb_bus_arb2.sv
// Self-checking bench for bus_arb2: per-cycle vector table plus a
// scoreboard-checked back-to-back read stream from both masters.
module tb_bus_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m1_ack, m0_resp, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_req, bus_we, bus_ack, bus_resp, resp_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bus_arb2 #(.RESP_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr),
        .m0_be_bi(m0_be), .m0_wdata_bi(m0_wdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr),
        .m1_be_bi(m1_be), .m1_wdata_bi(m1_wdata),
        .m0_ack_o(m0_ack), .m1_ack_o(m1_ack),
        .m0_resp_o(m0_resp), .m1_resp_o(m1_resp),
        .m0_rdata_bo(m0_rdata), .m1_rdata_bo(m1_rdata),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_bo(bus_addr),
        .bus_be_bo(bus_be), .bus_wdata_bo(bus_wdata),
        .bus_ack_i(bus_ack), .bus_resp_i(bus_resp), .bus_rdata_bi(bus_rdata),
        .resp_err_o(resp_err)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        r0, w0;
        logic [31:0] a0;
        logic        r1, w1;
        logic [31:0] a1;
        logic        ack, resp;
        logic [31:0] rdata;
        logic        x_req, x_gnt;
        logic [1:0]  x_ack, x_resp;
        logic        x_err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb_q[$];

    function automatic vec_t mk(string name, logic rs, logic r0, logic w0, logic [31:0] a0,
                                logic r1, logic w1, logic [31:0] a1, logic ack, logic resp,
                                logic [31:0] rd, logic xreq, logic xg, logic [1:0] xa,
                                logic [1:0] xr, logic xe);
        vec_t v;
        v.name = name; v.rst = rs;
        v.r0 = r0; v.w0 = w0; v.a0 = a0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.ack = ack; v.resp = resp; v.rdata = rd;
        v.x_req = xreq; v.x_gnt = xg; v.x_ack = xa; v.x_resp = xr; v.x_err = xe;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0000_0000;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0000_0000;
        bus_ack = 1'b0; bus_resp = 1'b0; bus_rdata = 32'h0000_0000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one vector just after a rising edge, check just before the next.
    task automatic apply(vec_t v);
        logic [31:0] x_addr, x_wdata;
        logic [3:0]  x_be;
        logic        x_we;
        rst = v.rst;
        m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0;
        m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1;
        bus_ack = v.ack; bus_resp = v.resp; bus_rdata = v.rdata;
        #4;
        x_addr  = v.x_gnt ? v.a1 : v.a0;
        x_we    = v.x_gnt ? v.w1 : v.w0;
        x_be    = v.x_gnt ? m1_be : m0_be;
        x_wdata = v.x_gnt ? m1_wdata : m0_wdata;
        check({v.name, "/ctl"}, 64'({bus_req, m0_ack, m1_ack, m0_resp, m1_resp, resp_err}),
              64'({v.x_req, v.x_ack, v.x_resp, v.x_err}));
        check({v.name, "/fields"}, {bus_addr, bus_wdata}, {x_addr, x_wdata});
        check({v.name, "/we_be"}, 64'({bus_we, bus_be}), 64'({x_we, x_be}));
        if (v.x_resp != 2'b00) begin
            check({v.name, "/rdata"}, {m0_rdata, m1_rdata}, {v.rdata, v.rdata});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        sb_t e;
        logic model_last;
        logic exp_g;
        int   n_stream;

        m0_be = 4'hF; m1_be = 4'h3;
        m0_wdata = 32'h0000_00A0; m1_wdata = 32'h0000_00B1;

        //            name              rst r0 w0 a0            r1 w1 a1            ack resp rdata         xreq xg  xack   xresp  xerr
        tbl.push_back(mk("rst_state",   0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("m0_rd_ack",   0, 1, 0, 32'h100,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("m0_resp",     0, 0, 0, 32'h0,       1, 0, 32'h400,     1, 1, 32'hDEADBEEF,  1, 1, 2'b01, 2'b10, 0));
        tbl.push_back(mk("m1_wr_wait0", 0, 0, 0, 32'h0,       1, 1, 32'h204,     0, 1, 32'h11111111,  1, 1, 2'b00, 2'b01, 0));
        tbl.push_back(mk("m1_wr_wait1", 0, 1, 0, 32'h300,     1, 1, 32'h204,     0, 0, 32'h0,         1, 1, 2'b00, 2'b00, 0));
        tbl.push_back(mk("m1_wr_ack",   0, 1, 0, 32'h300,     1, 1, 32'h204,     1, 0, 32'h0,         1, 1, 2'b01, 2'b00, 0));
        tbl.push_back(mk("m0_next",     0, 1, 0, 32'h300,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("m0_resp2",    0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'hCAFEF00D,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("fill0",       0, 1, 0, 32'h500,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("fill1",       0, 1, 0, 32'h504,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("fill2",       0, 1, 0, 32'h508,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("fill3",       0, 1, 0, 32'h50C,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("full_stall",  0, 1, 0, 32'h510,     0, 0, 32'h0,       1, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("full_pop",    0, 1, 0, 32'h510,     0, 0, 32'h0,       1, 1, 32'h12345678,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("after_pop",   0, 1, 0, 32'h510,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("drain0",      0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h00000F00,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("drain1",      0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h00000F01,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("drain2",      0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h00000F02,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("drain3",      0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h00000F03,  0, 0, 2'b00, 2'b10, 0));
        tbl.push_back(mk("err_resp",    0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h0,         0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("err_set",     0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(mk("err_sticky",  0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(mk("rst_pulse",   1, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(mk("err_cleared", 0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("out_rd0",     0, 1, 0, 32'h600,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("out_rd1",     0, 1, 0, 32'h604,     0, 0, 32'h0,       1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));
        tbl.push_back(mk("rst_mid",     1, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("stale_resp",  0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 1, 32'h55555555,  0, 0, 2'b00, 2'b00, 0));
        tbl.push_back(mk("stale_err",   0, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(mk("rst_again",   1, 0, 0, 32'h0,       0, 0, 32'h0,       0, 0, 32'h0,         0, 0, 2'b00, 2'b00, 1));
        tbl.push_back(mk("tie_m0",      0, 1, 0, 32'h700,     1, 0, 32'h704,     1, 0, 32'h0,         1, 0, 2'b10, 2'b00, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Back-to-back reads from both masters with a one-cycle response pipeline.
        do_reset();
        model_last = 1'b1;
        n_stream = 10;
        for (int c = 0; c <= n_stream; c++) begin
            m0_req = (c < n_stream); m0_we = 1'b0; m0_addr = 32'h800 + 32'(4 * c);
            m1_req = (c < n_stream); m1_we = 1'b0; m1_addr = 32'h900 + 32'(4 * c);
            bus_ack = (c < n_stream);
            bus_resp = (c > 0);
            bus_rdata = 32'hA000_0000 + 32'(c - 1);
            #4;
            if (c < n_stream) begin
                exp_g = ~model_last;
                check($sformatf("rr_ack%0d", c), 64'({m0_ack, m1_ack}),
                      64'(exp_g ? 2'b01 : 2'b10));
                e.id = exp_g;
                e.data = 32'hA000_0000 + 32'(c);
                sb_q.push_back(e);
                model_last = exp_g;
            end
            if (c > 0) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rr_sb%0d: scoreboard empty", c);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("rr_resp%0d", c), 64'({m0_resp, m1_resp}),
                          64'(e.id ? 2'b01 : 2'b10));
                    check($sformatf("rr_rdata%0d", c), 64'(e.id ? m1_rdata : m0_rdata),
                          64'(e.data));
                end
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        #4;
        check("rr_no_err", 64'(resp_err), 64'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
